// File: rtl/pc_sequencer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pc_sequencer_pkg : op-code encodings for the program-counter seq.  |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
package pc_sequencer_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_NOP      = 3'd0;
  localparam logic [OP_W-1:0] OP_INC      = 3'd1;
  localparam logic [OP_W-1:0] OP_LATCH_LO = 3'd2;
  localparam logic [OP_W-1:0] OP_JUMP     = 3'd3;
  localparam logic [OP_W-1:0] OP_BRANCH   = 3'd4;
  localparam logic [OP_W-1:0] OP_CALL     = 3'd5;
  localparam logic [OP_W-1:0] OP_RET      = 3'd6;
  localparam logic [OP_W-1:0] OP_RSVD     = 3'd7;

endpackage
`default_nettype wire

// File: rtl/pc_return_stack.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pc_return_stack : LIFO of return addresses; drops illegal push/pop |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module pc_return_stack #(
  parameter int ADDR_W      = 16,
  parameter int STACK_DEPTH = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               push,
  input  logic                               pop,
  input  logic [ADDR_W-1:0]                  push_data,
  output logic [ADDR_W-1:0]                  top,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
  output logic                               full,
  output logic                               empty
);

  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ADDR_W-1:0]  mem_q [STACK_DEPTH];
  logic [DEPTH_W-1:0] depth_q;
  logic [DEPTH_W-1:0] depth_d;
  logic [IDX_W-1:0]   wr_idx;
  logic [IDX_W-1:0]   rd_idx;
  logic               do_push;
  logic               do_pop;

  always_comb begin
    full    = (depth_q == DEPTH_W'(STACK_DEPTH));
    empty   = (depth_q == '0);
    do_push = push && !full;
    do_pop  = pop && !empty;
    wr_idx  = IDX_W'(depth_q);
    rd_idx  = IDX_W'(depth_q - DEPTH_W'(1));
    depth_d = depth_q;
    if (do_push) begin
      depth_d = depth_q + DEPTH_W'(1);
    end else if (do_pop) begin
      depth_d = depth_q - DEPTH_W'(1);
    end
    // Top is only meaningful when non-empty; rd_idx wraps harmlessly otherwise.
    top   = mem_q[rd_idx];
    depth = depth_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      depth_q <= '0;
    end else begin
      depth_q <= depth_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && do_push) begin
      mem_q[wr_idx] <= push_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pc_sequencer : byte-sliced program counter with call/return stack  |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int                    DATA_W       = 8,
  parameter int                    STACK_DEPTH  = 8,
  parameter logic [2*DATA_W-1:0]   RESET_VECTOR = '0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [OP_W-1:0]                    op,
  input  logic [DATA_W-1:0]                  in,
  output logic [DATA_W-1:0]                  pc_low,
  output logic [DATA_W-1:0]                  pc_high,
  output logic [2*DATA_W-1:0]                pc,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_depth,
  output logic                               stack_empty,
  output logic                               stack_full,
  output logic                               stack_err
);

  localparam int ADDR_W = 2 * DATA_W;

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic [DATA_W-1:0] staging_q;
  logic [DATA_W-1:0] staging_d;
  logic              err_q;
  logic              err_d;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] branch_off;
  logic [ADDR_W-1:0] stk_top;
  logic              stk_full;
  logic              stk_empty;

  pc_return_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .top       (stk_top),
    .depth     (stack_depth),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  always_comb begin
    pc_inc     = pc_q + ADDR_W'(1);
    branch_off = {{DATA_W{in[DATA_W-1]}}, in};
    pc_d       = pc_q;
    staging_d  = staging_q;
    err_d      = err_q;
    push       = 1'b0;
    pop        = 1'b0;
    case (op)
      OP_INC:      pc_d = pc_inc;
      OP_LATCH_LO: staging_d = in;
      OP_JUMP:     pc_d = {in, staging_q};
      OP_BRANCH:   pc_d = pc_inc + branch_off;
      OP_CALL: begin
        if (stk_full) begin
          err_d = 1'b1;
        end else begin
          push = 1'b1;
          pc_d = {in, staging_q};
        end
      end
      OP_RET: begin
        if (stk_empty) begin
          err_d = 1'b1;
        end else begin
          pop  = 1'b1;
          pc_d = stk_top;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= RESET_VECTOR;
      staging_q <= '0;
      err_q     <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      staging_q <= staging_d;
      err_q     <= err_d;
    end
  end

  assign pc          = pc_q;
  assign pc_low      = pc_q[DATA_W-1:0];
  assign pc_high     = pc_q[ADDR_W-1:DATA_W];
  assign stack_empty = stk_empty;
  assign stack_full  = stk_full;
  assign stack_err   = err_q;

endmodule
`default_nettype wire
